// File: rtl/simprisc_exec_core.sv
// SimpRISC execute stage: valid/ready instruction intake, 8-entry register file,
// single-cycle ALU plus a multi-cycle multiply, and a registered result port.
module simprisc_exec_core #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [2:0]        res_rd,
    output logic              res_err,
    output logic              busy,
    output logic [15:0]       retired_cnt
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_ADDI = 4'd8,
        OP_MUL  = 4'd9,
        OP_LDI  = 4'd10
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MUL_BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  mul_cnt;
    logic [DATA_W-1:0] mul_a, mul_b;
    logic [2:0]        mul_rd;
    logic [DATA_W-1:0] regs [8];

    logic [3:0]        op;
    logic [2:0]        rd, rs1, rs2;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] imm6_ext, imm9_ext, mul_prod;
    logic [DATA_W-1:0] exec_data;
    logic              exec_err, exec_wb;

    logic              accept, slot_free, mul_done, load;
    logic [DATA_W-1:0] load_data;
    logic [2:0]        load_rd;
    logic              load_err, load_wb;

    assign op       = in_instr[15:12];
    assign rd       = in_instr[11:9];
    assign rs1      = in_instr[8:6];
    assign rs2      = in_instr[5:3];
    // r0 is never written and resets to zero, so a plain read already returns 0.
    assign rs1_val  = regs[rs1];
    assign rs2_val  = regs[rs2];
    assign shamt    = rs2_val[SH_W-1:0];
    assign imm6_ext = DATA_W'($signed(in_instr[5:0]));
    assign imm9_ext = DATA_W'($signed(in_instr[8:0]));
    assign mul_prod = mul_a * mul_b;

    assign slot_free = !res_valid || res_ready;
    assign in_ready  = !rst && (state_q == S_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign mul_done  = (state_q == S_MUL_BUSY) && (mul_cnt == '0) && slot_free;
    assign load      = (accept && (op != OP_MUL)) || mul_done;

    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise an uncovered case path infers a latch.
    always_comb begin
        exec_data = '0;
        exec_err  = 1'b0;
        exec_wb   = 1'b1;
        case (op)
            OP_NOP:  exec_wb   = 1'b0;
            OP_ADD:  exec_data = rs1_val + rs2_val;
            OP_SUB:  exec_data = rs1_val - rs2_val;
            OP_AND:  exec_data = rs1_val & rs2_val;
            OP_OR:   exec_data = rs1_val | rs2_val;
            OP_XOR:  exec_data = rs1_val ^ rs2_val;
            OP_SHL:  exec_data = rs1_val << shamt;
            OP_SHR:  exec_data = rs1_val >> shamt;
            OP_ADDI: exec_data = rs1_val + imm6_ext;
            OP_LDI:  exec_data = imm9_ext;
            OP_MUL:  exec_wb   = 1'b0;
            default: begin
                exec_err = 1'b1;
                exec_wb  = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_data = exec_data;
        load_rd   = rd;
        load_err  = exec_err;
        load_wb   = exec_wb;
        if (mul_done) begin
            load_data = mul_prod;
            load_rd   = mul_rd;
            load_err  = 1'b0;
            load_wb   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q == S_MUL_BUSY);
        case (state_q)
            S_IDLE:     if (accept && (op == OP_MUL)) state_d = S_MUL_BUSY;
            S_MUL_BUSY: if (mul_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mul_cnt     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_rd      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_rd      <= '0;
            res_err     <= 1'b0;
            retired_cnt <= '0;
            // NOTE: the register file is architecturally zero after reset, so
            // it is reset explicitly rather than left as uninitialised memory.
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;

            if (accept && (op == OP_MUL)) begin
                mul_cnt <= CNT_W'(MUL_CYCLES - 1);
                mul_a   <= rs1_val;
                mul_b   <= rs2_val;
                mul_rd  <= rd;
            end else if ((state_q == S_MUL_BUSY) && (mul_cnt != '0)) begin
                mul_cnt <= mul_cnt - 1'b1;
            end

            if (load) begin
                res_valid   <= 1'b1;
                res_data    <= load_data;
                res_rd      <= load_rd;
                res_err     <= load_err;
                retired_cnt <= retired_cnt + 16'd1;
                if (load_wb && (load_rd != 3'd0)) regs[load_rd] <= load_data;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simprisc_exec_core.sv
// Directed bench for simprisc_exec_core: a driver pushes expected results into a
// queue on acceptance; an independent monitor pops and compares on each consumed result.
module tb_simprisc_exec_core;

    localparam int DATA_W     = 16;
    localparam int MUL_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [2:0]        res_rd;
    logic              res_err;
    logic              busy;
    logic [15:0]       retired_cnt;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_res  = 0;

    simprisc_exec_core #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_err    (res_err),
        .busy       (busy),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] r3(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [5:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'hA, rd, imm};
    endfunction

    // Offer one instruction; on acceptance optionally record its expected result.
    task automatic send(input logic [15:0] ins, input logic [15:0] d, input logic [2:0] rd,
                        input logic err, input bit push);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        end else if (push) begin
            exp_q.push_back('{data: d, rd: rd, err: err});
            n_res++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 'x;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", exp_q.size(), 32'd0);
    endtask

    // Monitor: every consumed result must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got data=%h rd=%0d err=%b (t=%0t)",
                             res_data, res_rd, res_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("result{data,rd,err}", {12'b0, res_data, res_rd, res_err},
                          {12'b0, e.data, e.rd, e.err});
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_res_data",  {16'b0, res_data},  32'd0);
        check("rst_retired",   {16'b0, retired_cnt}, 32'd0);
        rst = 1'b0;

        // Back-to-back single-cycle ops.
        send(ldi(3'd1, 9'd5),         16'd5,      3'd1, 1'b0, 1);
        send(ldi(3'd2, 9'h1FD),       16'hFFFD,   3'd2, 1'b0, 1);
        send(r3(4'd1, 3'd3, 3'd1, 3'd2), 16'd2,   3'd3, 1'b0, 1);
        drain();

        // Multiply latency and busy window.
        send(ldi(3'd1, 9'd7), 16'd7, 3'd1, 1'b0, 1);
        send(ldi(3'd2, 9'd6), 16'd6, 3'd2, 1'b0, 1);
        send(r3(4'd9, 3'd4, 3'd1, 3'd2), 16'd42, 3'd4, 1'b0, 1);
        for (int i = 0; i < MUL_CYCLES; i++) begin
            check("mul_busy",      {31'b0, busy},      32'd1);
            check("mul_in_ready",  {31'b0, in_ready},  32'd0);
            check("mul_res_valid", {31'b0, res_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("mul_done_valid", {31'b0, res_valid}, 32'd1);
        check("mul_done_busy",  {31'b0, busy},      32'd0);
        check("mul_done_data",  {16'b0, res_data},  32'd42);
        drain();

        // Backpressure: result frozen while not consumed.
        res_ready = 1'b0;
        send(r3(4'd1, 3'd3, 3'd1, 3'd2), 16'd13, 3'd3, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",    {31'b0, res_valid}, 32'd1);
            check("stall_data",     {16'b0, res_data},  32'd13);
            check("stall_in_ready", {31'b0, in_ready},  32'd0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        drain();

        // r0 behaviour, illegal opcode, NOP; r1 must still hold 7.
        send(ldi(3'd0, 9'd9),            16'd9, 3'd0, 1'b0, 1);
        send(r3(4'd1, 3'd5, 3'd0, 3'd0), 16'd0, 3'd5, 1'b0, 1);
        send(16'hC200,                   16'd0, 3'd1, 1'b1, 1);
        send(r3(4'd1, 3'd3, 3'd1, 3'd0), 16'd7, 3'd3, 1'b0, 1);
        send(16'h0200,                   16'd0, 3'd1, 1'b0, 1);
        send(r3(4'd1, 3'd3, 3'd1, 3'd0), 16'd7, 3'd3, 1'b0, 1);

        // Shifts, logic ops, ADDI sign extension.
        send(ldi(3'd1, 9'd1),            16'd1,     3'd1, 1'b0, 1);
        send(ldi(3'd2, 9'd17),           16'd17,    3'd2, 1'b0, 1);
        send(r3(4'd6, 3'd6, 3'd1, 3'd2), 16'd2,     3'd6, 1'b0, 1);
        send(r3(4'd7, 3'd7, 3'd2, 3'd1), 16'd8,     3'd7, 1'b0, 1);
        send(r3(4'd2, 3'd3, 3'd1, 3'd2), 16'hFFF0,  3'd3, 1'b0, 1);
        send(r3(4'd3, 3'd3, 3'd1, 3'd2), 16'd1,     3'd3, 1'b0, 1);
        send(r3(4'd4, 3'd3, 3'd1, 3'd2), 16'd17,    3'd3, 1'b0, 1);
        send(r3(4'd5, 3'd3, 3'd1, 3'd2), 16'd16,    3'd3, 1'b0, 1);
        send(ldi(3'd1, 9'd0),            16'd0,     3'd1, 1'b0, 1);
        send(ri(4'd8, 3'd1, 3'd1, 6'h20), 16'hFFE0, 3'd1, 1'b0, 1);
        send(ri(4'd8, 3'd2, 3'd1, 6'h1F), 16'hFFFF, 3'd2, 1'b0, 1);
        drain();
        check("retired_cnt", {16'b0, retired_cnt}, n_res);

        // Reset in the middle of a multiply: nothing may be emitted.
        send(r3(4'd9, 3'd4, 3'd1, 3'd2), 16'd0, 3'd4, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midmul_busy",      {31'b0, busy},        32'd0);
        check("midmul_res_valid", {31'b0, res_valid},   32'd0);
        check("midmul_in_ready",  {31'b0, in_ready},    32'd0);
        check("midmul_retired",   {16'b0, retired_cnt}, 32'd0);
        rst   = 1'b0;
        n_res = 0;
        for (int i = 0; i < MUL_CYCLES + 2; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_result", {31'b0, res_valid}, 32'd0);
        end
        for (int r = 1; r < 8; r++)
            send(r3(4'd1, 3'(r), 3'(r), 3'd0), 16'd0, 3'(r), 1'b0, 1);
        drain();
        check("post_rst_retired", {16'b0, retired_cnt}, n_res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
